// File: rtl/spi_slave_param.sv
// SPI slave with clk-domain oversampling of SCK/SSEL/MOSI, configurable word widths,
// SPI mode and bit order, multi-word streaming per frame and truncated-frame reporting.
`timescale 1ns/1ps
module spi_slave_param #(
  parameter int unsigned RX_WIDTH    = 32,
  parameter int unsigned TX_WIDTH    = 16,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  parameter bit          MSB_FIRST   = 1'b1,
  parameter int unsigned SYNC_STAGES = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                SCK,
  input  logic                SSEL,
  input  logic                MOSI,
  output logic                MISO,
  output logic                MISO_OE,
  input  logic [TX_WIDTH-1:0] READ_OUT,
  output logic                TX_LOAD,
  output logic [RX_WIDTH-1:0] DATA_OUT,
  output logic                DATA_READY,
  output logic                FRAME_ERR
);

  // state  | meaning
  // IDLE   | no frame; waiting for a qualified SSEL falling edge
  // ACTIVE | frame in progress; shifting RX/TX on SCK edges
  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  localparam int unsigned RCW = $clog2(RX_WIDTH + 1);
  localparam int unsigned TCW = $clog2(TX_WIDTH);
  localparam logic [RCW-1:0] RX_FULL = RCW'(RX_WIDTH);
  localparam logic [TCW-1:0] TX_LAST = TCW'(TX_WIDTH - 1);
  localparam int unsigned S = SYNC_STAGES;

  state_t state_q, state_d;

  logic [S-1:0] sck_s_q, ssel_s_q, mosi_s_q, vld_q;
  logic         armed_q, armed_d;

  logic [RX_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [RCW-1:0]      rx_cnt_q, rx_cnt_d;
  logic [RX_WIDTH-1:0] dout_q, dout_d;
  logic                rdy_q, rdy_d, ferr_q, ferr_d;

  logic [TX_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [TCW-1:0]      tx_cnt_q, tx_cnt_d;
  logic                tx_live_q, tx_live_d;
  logic                tx_load_q, tx_load_d;
  logic                miso_q, miso_d;

  logic sck_rise, sck_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic ssel_real_high, ssel_fall, ssel_rise, mosi_bit;
  logic active, enter, leave;

  function automatic logic tx_bit(input logic [TX_WIDTH-1:0] v);
    return MSB_FIRST ? v[TX_WIDTH-1] : v[0];
  endfunction

  function automatic logic [TX_WIDTH-1:0] tx_adv(input logic [TX_WIDTH-1:0] v);
    return MSB_FIRST ? {v[TX_WIDTH-2:0], 1'b0} : {1'b0, v[TX_WIDTH-1:1]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_s_q  <= {S{CPOL}};
      ssel_s_q <= {S{1'b1}};
      mosi_s_q <= '0;
      vld_q    <= '0;
      armed_q  <= 1'b0;
    end else begin
      sck_s_q  <= {sck_s_q[S-2:0], SCK};
      ssel_s_q <= {ssel_s_q[S-2:0], SSEL};
      mosi_s_q <= {mosi_s_q[S-2:0], MOSI};
      vld_q    <= {vld_q[S-2:0], 1'b1};
      armed_q  <= armed_d;
    end
  end

  // The reset value of the SSEL synchroniser is not a real observation of SSEL,
  // so a falling edge only counts once a genuinely sampled high has been seen.
  assign ssel_real_high = vld_q[S-1] & ssel_s_q[S-1];
  assign armed_d        = armed_q | ssel_real_high;
  assign ssel_fall      = armed_d & ssel_s_q[S-1] & ~ssel_s_q[S-2];
  assign ssel_rise      = ~ssel_s_q[S-1] & ssel_s_q[S-2];

  assign sck_rise    = sck_s_q[S-2] & ~sck_s_q[S-1];
  assign sck_fall    = ~sck_s_q[S-2] & sck_s_q[S-1];
  assign lead_edge   = CPOL ? sck_fall : sck_rise;
  assign trail_edge  = CPOL ? sck_rise : sck_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign mosi_bit    = mosi_s_q[S-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ssel_fall) state_d = ACTIVE;
      ACTIVE:  if (ssel_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign active = (state_q == ACTIVE);
  assign enter  = (state_q == IDLE) & ssel_fall;
  assign leave  = active & ssel_rise;

  // A word completed on the same clk as SSEL rising is still delivered next clk.
  always_comb begin
    rx_shift_d = rx_shift_q;
    rx_cnt_d   = rx_cnt_q;
    dout_d     = dout_q;
    rdy_d      = 1'b0;
    ferr_d     = 1'b0;
    if (rx_cnt_q == RX_FULL) begin
      dout_d   = rx_shift_q;
      rdy_d    = 1'b1;
      rx_cnt_d = '0;
    end else if (active && sample_edge) begin
      rx_shift_d = MSB_FIRST ? {rx_shift_q[RX_WIDTH-2:0], mosi_bit}
                             : {mosi_bit, rx_shift_q[RX_WIDTH-1:1]};
      rx_cnt_d   = rx_cnt_q + RCW'(1);
    end
    if (enter) begin
      rx_cnt_d = '0;
    end else if (leave && (rx_cnt_d != RX_FULL)) begin
      ferr_d   = (rx_cnt_d != '0);
      rx_cnt_d = '0;
    end
  end

  // With CPHA=1 the first shift edge only exposes the first bit.
  always_comb begin
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    tx_live_d  = tx_live_q;
    tx_load_d  = 1'b0;
    if (enter) begin
      tx_shift_d = READ_OUT;
      tx_load_d  = 1'b1;
      tx_cnt_d   = '0;
      tx_live_d  = ~CPHA;
    end else if (leave) begin
      tx_cnt_d  = '0;
      tx_live_d = 1'b0;
    end else if (active && shift_edge) begin
      if (!tx_live_q) begin
        tx_live_d = 1'b1;
      end else if (tx_cnt_q == TX_LAST) begin
        tx_shift_d = READ_OUT;
        tx_load_d  = 1'b1;
        tx_cnt_d   = '0;
      end else begin
        tx_shift_d = tx_adv(tx_shift_q);
        tx_cnt_d   = tx_cnt_q + TCW'(1);
      end
    end
    miso_d = ((state_d == ACTIVE) && tx_live_d) ? tx_bit(tx_shift_d) : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift_q <= '0;
      rx_cnt_q   <= '0;
      dout_q     <= '0;
      rdy_q      <= 1'b0;
      ferr_q     <= 1'b0;
      tx_shift_q <= '0;
      tx_cnt_q   <= '0;
      tx_live_q  <= 1'b0;
      tx_load_q  <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      rx_shift_q <= rx_shift_d;
      rx_cnt_q   <= rx_cnt_d;
      dout_q     <= dout_d;
      rdy_q      <= rdy_d;
      ferr_q     <= ferr_d;
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_live_q  <= tx_live_d;
      tx_load_q  <= tx_load_d;
      miso_q     <= miso_d;
    end
  end

  assign MISO       = miso_q;
  assign MISO_OE    = active;
  assign TX_LOAD    = tx_load_q;
  assign DATA_OUT   = dout_q;
  assign DATA_READY = rdy_q;
  assign FRAME_ERR  = ferr_q;

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: a default mode-0 32/16 instance driven from a vector table
// with a word scoreboard, plus a CPOL=1/CPHA=1 LSB-first 8/8 instance.
`timescale 1ns/1ps
module tb_spi_slave_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sck0, ssel0, mosi0, miso0, oe0, load0, rdy0, ferr0;
  logic [15:0] rd0;
  logic [31:0] dout0;

  logic        sck1, ssel1, mosi1, miso1, oe1, load1, rdy1, ferr1;
  logic [7:0]  rd1, dout1;

  spi_slave_param dut0 (
    .clk(clk), .rst_n(rst_n), .SCK(sck0), .SSEL(ssel0), .MOSI(mosi0),
    .MISO(miso0), .MISO_OE(oe0), .READ_OUT(rd0), .TX_LOAD(load0),
    .DATA_OUT(dout0), .DATA_READY(rdy0), .FRAME_ERR(ferr0)
  );

  spi_slave_param #(.RX_WIDTH(8), .TX_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1),
                    .MSB_FIRST(1'b0), .SYNC_STAGES(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .SCK(sck1), .SSEL(ssel1), .MOSI(mosi1),
    .MISO(miso1), .MISO_OE(oe1), .READ_OUT(rd1), .TX_LOAD(load1),
    .DATA_OUT(dout1), .DATA_READY(rdy1), .FRAME_ERR(ferr1)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];
  logic [31:0] sb_exp;
  int n_rdy0, n_ferr0, n_load0, n_rdy1, n_ferr1, n_load1;

  typedef struct {
    int          nbits;
    logic [63:0] mosi;
    logic [15:0] rd;
    int          exp_rdy;
    int          exp_ferr;
    int          exp_load;
    logic [31:0] exp_dout;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rdy0) begin
        n_rdy0++;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dr_unexpected: got DATA_OUT %0h with no word expected", dout0);
        end else begin
          sb_exp = sb_q.pop_front();
          chk("sb_data_out", {32'h0, dout0}, {32'h0, sb_exp});
        end
      end
      if (ferr0) n_ferr0++;
      if (load0) n_load0++;
      if (rdy1)  n_rdy1++;
      if (ferr1) n_ferr1++;
      if (load1) n_load1++;
    end
  end

  task automatic clr_counts();
    n_rdy0 = 0; n_ferr0 = 0; n_load0 = 0;
    n_rdy1 = 0; n_ferr1 = 0; n_load1 = 0;
  endtask

  // Mode 0 master bit: MOSI set while SCK low, MISO captured at the rising edge.
  task automatic bit0(input logic b, output logic m);
    mosi0 = b;
    wait_clk(8);
    m = miso0;
    sck0 = 1'b1;
    wait_clk(8);
    sck0 = 1'b0;
  endtask

  task automatic frame0(input int nbits, input logic [63:0] mosi, input logic [15:0] rd,
                        output logic [15:0] got, output logic oe_in);
    logic m;
    rd0 = rd;
    for (int w = 0; w < nbits / 32; w++) sb_q.push_back(mosi[63 - 32*w -: 32]);
    ssel0 = 1'b0;
    wait_clk(8);
    oe_in = oe0;
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      bit0(mosi[63 - i], m);
      if (i < 16) got[15 - i] = m;
    end
    wait_clk(8);
    ssel0 = 1'b1;
    wait_clk(8);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        vt[5];
    logic [15:0] got;
    logic [7:0]  got1;
    logic        oe_in, m, oe_bad;

    vt[0] = '{32, 64'h8C8C8C8A_00000000, 16'hA3A3, 1, 0, 3, 32'h8C8C8C8A};
    vt[1] = '{16, 64'hFFFF0000_00000000, 16'hA3A3, 0, 1, 2, 32'h8C8C8C8A};
    vt[2] = '{64, 64'h12345678_9ABCDEF0, 16'h5A0F, 2, 0, 5, 32'h9ABCDEF0};
    vt[3] = '{20, 64'hABCDE000_00000000, 16'hFFFF, 0, 1, 2, 32'h9ABCDEF0};
    vt[4] = '{32, 64'hDEADBEEF_00000000, 16'h0001, 1, 0, 3, 32'hDEADBEEF};

    sck0 = 1'b0; ssel0 = 1'b1; mosi0 = 1'b0; rd0 = '0;
    sck1 = 1'b1; ssel1 = 1'b1; mosi1 = 1'b0; rd1 = '0;
    clr_counts();

    rst_n = 1'b0;
    wait_clk(4);
    chk("rst_miso_oe", oe0, 0);
    chk("rst_miso", miso0, 0);
    chk("rst_data_out", dout0, 0);
    chk("rst_data_ready", rdy0, 0);
    chk("rst_frame_err", ferr0, 0);
    chk("rst_tx_load", load0, 0);
    chk("rst_data_out1", dout1, 0);
    rst_n = 1'b1;
    wait_clk(10);

    for (int i = 0; i < 5; i++) begin
      clr_counts();
      frame0(vt[i].nbits, vt[i].mosi, vt[i].rd, got, oe_in);
      chk($sformatf("v%0d_ready_pulses", i), n_rdy0, vt[i].exp_rdy);
      chk($sformatf("v%0d_frame_err", i), n_ferr0, vt[i].exp_ferr);
      chk($sformatf("v%0d_tx_load", i), n_load0, vt[i].exp_load);
      chk($sformatf("v%0d_miso_read", i), got, vt[i].rd);
      chk($sformatf("v%0d_oe_in_frame", i), oe_in, 1);
      chk($sformatf("v%0d_oe_after", i), oe0, 0);
      chk($sformatf("v%0d_miso_after", i), miso0, 0);
      chk($sformatf("v%0d_data_out", i), dout0, vt[i].exp_dout);
      chk($sformatf("v%0d_sb_empty", i), sb_q.size(), 0);
    end

    // Reset in the middle of a frame, released with SSEL still low.
    clr_counts();
    ssel0 = 1'b0;
    wait_clk(8);
    for (int i = 0; i < 10; i++) bit0(i[0], m);
    rst_n = 1'b0;
    #1;
    chk("midrst_oe", oe0, 0);
    chk("midrst_data_out", dout0, 0);
    chk("midrst_miso", miso0, 0);
    wait_clk(3);
    rst_n = 1'b1;
    oe_bad = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bit0(~i[0], m);
      oe_bad = oe_bad | oe0;
    end
    chk("midrst_oe_stays_low", oe_bad, 0);
    chk("midrst_no_ready", n_rdy0, 0);
    wait_clk(8);
    ssel0 = 1'b1;
    wait_clk(8);
    chk("midrst_no_frame_err", n_ferr0, 0);
    chk("midrst_data_out_hold", dout0, 0);
    clr_counts();
    frame0(32, 64'hCAFEF00D_00000000, 16'h1234, got, oe_in);
    chk("postrst_ready", n_rdy0, 1);
    chk("postrst_data_out", dout0, 32'hCAFEF00D);
    chk("postrst_miso_read", got, 16'h1234);
    chk("postrst_oe_in_frame", oe_in, 1);

    // CPOL=1/CPHA=1, LSB first: master shifts on falling SCK, samples on rising.
    clr_counts();
    rd1 = 8'hC3;
    got1 = '0;
    ssel1 = 1'b0;
    wait_clk(8);
    chk("m3_oe_in_frame", oe1, 1);
    for (int i = 0; i < 8; i++) begin
      sck1 = 1'b0;
      mosi1 = sb_exp[0] ^ sb_exp[0] ^ ((8'h5A >> i) & 8'h01) != 0;
      wait_clk(8);
      got1[i] = miso1;
      sck1 = 1'b1;
      wait_clk(8);
    end
    wait_clk(8);
    ssel1 = 1'b1;
    wait_clk(8);
    chk("m3_data_out", dout1, 8'h5A);
    chk("m3_ready", n_rdy1, 1);
    chk("m3_frame_err", n_ferr1, 0);
    chk("m3_tx_load", n_load1, 1);
    chk("m3_miso_read", got1, 8'hC3);
    chk("m3_oe_after", oe1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_param.md
Name: spi_slave_param

Overview:
Parametrised successor to the SPI_SLAVE command port. It oversamples SCK, SSEL and MOSI in the system clock domain through synchronisers. The receive and transmit word widths, SPI mode (CPOL/CPHA) and bit order are configurable. It supports multi-word streaming within one SSEL frame and reports truncated frames. It sits between the external MCU SPI master and the FPGA command decoder and register readback mux.

Parameters:
RX_WIDTH, 32, bits per received command word (MOSI), 8..64
TX_WIDTH, 16, bits per transmitted readback word (MISO), 8..64
CPOL, 0, SCK idle level
CPHA, 0, 0 = sample on leading edge and shift on trailing edge; 1 = shift on leading edge and sample on trailing edge
MSB_FIRST, 1, 1 = MSB shifted first on both MOSI and MISO; 0 = LSB first
SYNC_STAGES, 3, flip-flop stages on SCK/SSEL/MOSI, minimum 2

Ports:
clk  input  1  system clock; all logic runs on its rising edge
rst_n  input  1  asynchronous active-low reset
SCK  input  1  SPI clock from the master, asynchronous to clk
SSEL  input  1  active-low chip select, asynchronous
MOSI  input  1  serial data in
MISO  output  1  serial data out
MISO_OE  output  1  high while the frame is active; the top level tri-states MISO when this is low
READ_OUT  input  TX_WIDTH  parallel word to shift out
TX_LOAD  output  1  one-clk pulse when READ_OUT is captured into the TX shifter
DATA_OUT  output  RX_WIDTH  last complete received word
DATA_READY  output  1  one-clk pulse when DATA_OUT is updated
FRAME_ERR  output  1  one-clk pulse when SSEL deasserts with a partial RX word

Behaviour:
- Reset values: MISO=0, MISO_OE=0, TX_LOAD=0, DATA_OUT=0, DATA_READY=0, FRAME_ERR=0, state=IDLE, all counters 0, synchroniser flops set to SCK=CPOL, SSEL=1, MOSI=0.
- Synchronisers:
  - SCK, SSEL and MOSI each pass through SYNC_STAGES flops.
  - Edges are detected on the last two SCK and SSEL stages.
  - MOSI is sampled from its last stage.
  - Requirement on the master: SCK high and low times are each at least SYNC_STAGES+1 clk periods.
- Edge mapping:
  - leading edge = rising if CPOL=0, falling if CPOL=1.
  - sample edge = leading if CPHA=0, else trailing.
  - shift edge = the other edge.
- State machine:
  - IDLE to ACTIVE on the synchronised SSEL falling edge.
  - ACTIVE to IDLE on the synchronised SSEL rising edge.
  - If SSEL is already low when reset releases, the block stays IDLE until SSEL is seen high and then low again.
- Entry to ACTIVE, same clk:
  - READ_OUT is loaded into the TX shifter and TX_LOAD pulses.
  - rx_cnt=0, tx_cnt=0, MISO_OE=1.
  - If CPHA=0, MISO presents the first bit (READ_OUT[TX_WIDTH-1] if MSB_FIRST, else READ_OUT[0]) on the next clk.
  - If CPHA=1, the first bit is presented after the first shift edge, and that first shift edge does not advance the shifter.
- RX path:
  - On each sample edge in ACTIVE, MOSI shifts into rx_shift (in at the LSB if MSB_FIRST, else in at the MSB) and rx_cnt increments.
  - When rx_cnt reaches RX_WIDTH, the next clk sets DATA_OUT to the completed word, pulses DATA_READY for 1 clk and resets rx_cnt to 0.
  - Further words in the same frame continue back-to-back.
- TX path:
  - On each counted shift edge, the shifter advances one bit and tx_cnt increments.
  - When tx_cnt reaches TX_WIDTH, READ_OUT is reloaded on that same clk (TX_LOAD pulses), so streaming continues without a gap.
  - MISO always reflects the shifter's output bit.
- Frame end (SSEL rising):
  - If rx_cnt is nonzero, FRAME_ERR pulses, DATA_OUT keeps its old value and there is no DATA_READY.
  - MISO_OE=0, MISO=0, and the counters clear.
- SCK edges while IDLE are ignored. MOSI is ignored while IDLE.
- Simultaneous events:
  - A sample edge completing a word in the same clk as SSEL rising: the word is delivered with DATA_READY and FRAME_ERR does not fire.
  - An SSEL falling edge while ACTIVE is impossible by construction and needs no handling.
- Asynchronous reset mid-frame immediately forces all reset values. Any partial word is discarded with no pulses.

Test Plan:
- Defaults, mode 0: SSEL low, 32 SCK cycles clocking MOSI=0x8C8C8C8A, SSEL high -> DATA_OUT=0x8C8C8C8A, exactly one DATA_READY pulse, FRAME_ERR never asserted.
- Read with READ_OUT=0xA3A3: 16 SCK cycles, master samples MISO on rising edges -> master reads 0xA3A3; TX_LOAD pulses once at frame start and once at the 16-bit boundary; MISO_OE=1 only inside the frame.
- Streaming: one frame of 64 SCK cycles with MOSI=0x12345678_9ABCDEF0 -> two DATA_READY pulses, with DATA_OUT=0x12345678 then 0x9ABCDEF0.
- Truncated frame: 20 SCK cycles then SSEL high -> FRAME_ERR pulses once, DATA_OUT unchanged, no DATA_READY; the next full 32-bit frame is received correctly.
- Mode and order sweep: CPOL=1/CPHA=1 and MSB_FIRST=0 with RX_WIDTH=8, TX_WIDTH=8 -> byte 0x5A received as 0x5A, and READ_OUT=0xC3 read back as 0xC3 by a matching-mode master.
- Reset mid-frame: assert rst_n low after 10 bits, release while SSEL is still low and keep clocking SCK -> no DATA_READY, MISO_OE stays 0 until a fresh SSEL high-then-low; after that, normal reception.
